traffic_phase_timer: RTL

//  Parametrised phase timer for the traffic-light controller; the successor of the fixed 6-bit counter.

---
 rtl/traffic_phase_timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic-light controller: counts ticks up to a programmable compare slot.
// Optional macro TPT_REMAIN_EN adds the 'remain' output (ticks left in the current phase).
module traffic_phase_timer #(
  parameter int CNT_W     = 6,
  parameter int N_SEL     = 4,
  parameter int SEL_W     = 2,
  parameter int DEF_LIMIT = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  input  logic             stop,
  input  logic [SEL_W-1:0] sel_compare,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [CNT_W-1:0] cnt,
  output logic             over_flag,
  output logic             busy
`ifdef TPT_REMAIN_EN
  ,
  output logic [CNT_W-1:0] remain
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_slot [N_SEL];
  logic [CNT_W-1:0] w_selLimit;
  logic             r_over;
  logic             w_nextOver;
  logic             w_relatch;
  logic             r_busy;
  logic             w_selOk;
  logic             w_addrOk;

  assign w_selOk    = ({1'b0, sel_compare} < (SEL_W+1)'(N_SEL));
  assign w_addrOk   = ({1'b0, cfg_addr} < (SEL_W+1)'(N_SEL));
  assign w_selLimit = w_selOk ? r_slot[sel_compare] : CNT_W'(DEF_LIMIT);

  // Slot writes land at the edge, so a limit latched on the same edge sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SEL; i++) begin
        r_slot[i] <= CNT_W'(DEF_LIMIT);
      end
    end else if (cfg_we && w_addrOk) begin
      r_slot[cfg_addr] <= cfg_data;
    end
  end

  // HOLD with en=1 behaves like an enabled RUN tick, so a pause costs exactly its length.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextOver  = 1'b0;
    w_relatch   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_nextCnt = '0;
        if (start) begin
          w_nextState = ST_RUN;
          w_relatch   = 1'b1;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (stop) begin
          w_nextState = ST_IDLE;
          w_nextCnt   = '0;
        end else if (!en) begin
          w_nextState = ST_HOLD;
        end else begin
          w_nextState = ST_RUN;
          if (r_cnt == r_limit) begin
            w_nextCnt  = '0;
            w_nextOver = 1'b1;
            w_relatch  = 1'b1;
          end else begin
            w_nextCnt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_over  <= 1'b0;
      r_busy  <= 1'b0;
      r_limit <= CNT_W'(DEF_LIMIT);
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_over  <= w_nextOver;
      r_busy  <= (w_nextState != ST_IDLE);
      if (w_relatch) begin
        r_limit <= w_selLimit;
      end
    end
  end

  assign cnt       = r_cnt;
  assign over_flag = r_over;
  assign busy      = r_busy;

`ifdef TPT_REMAIN_EN
  assign remain = r_limit - r_cnt;
`endif

endmodule
